// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage
//   MIPS-lite pipeline. Holds the PC, drives the instruction-memory address,
//   and registers the fetched word, its PC and a valid flag for the decoder.
//   Handles the hazard-unit stall, the EX-stage branch/JR redirect (with
//   flush of IF/ID), and stops fetching for good once a HALT has drained
//   out of IF/ID.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   reset          in   asynchronous active-high reset
//   stall          in   hold PC and IF/ID contents this cycle
//   redirect_valid in   taken branch / JR resolved in EX this cycle
//   redirect_pc    in   redirect target (low two bits ignored)
//   imem_addr      out  instruction-memory byte address (= PC)
//   imem_rdata     in   instruction word at imem_addr, same cycle
//   ifid_instr     out  registered instruction for the decoder
//   ifid_pc        out  registered PC of ifid_instr
//   ifid_valid     out  ifid_instr is a real instruction (0 = bubble)
//   halted         out  HALT has left IF/ID, fetch permanently stopped
//   fetch_count    out  saturating count of instructions fetched into IF/ID
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]            HALT_OPCODE = 6'b010001,
  parameter int                    CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [ADDR_WIDTH-1:0]  ifid_pc,
  output logic                   ifid_valid,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,  // HALT sits in IF/ID, an older branch may still squash it
    ST_HALTED    = 2'd2   // terminal until reset
  } state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [INSTR_WIDTH-1:0] ifid_instr_q;
  logic [ADDR_WIDTH-1:0]  ifid_pc_q;
  logic                   ifid_valid_q;
  logic                   halted_q;
  logic [CNT_WIDTH-1:0]   fetch_count_q;

  logic [5:0]             opcode;
  logic                   is_halt;
  logic [ADDR_WIDTH-1:0]  pc_seq_d;
  logic [ADDR_WIDTH-1:0]  redirect_tgt_d;
  logic [CNT_WIDTH-1:0]   fetch_count_d;

  assign opcode         = imem_rdata[INSTR_WIDTH-1 -: 6];
  assign is_halt        = (opcode == HALT_OPCODE);
  // Sequential PC wraps naturally at 2^ADDR_WIDTH.
  assign pc_seq_d       = pc_q + ADDR_WIDTH'(4);
  // Force word alignment of the redirect target.
  assign redirect_tgt_d = redirect_pc & ~ADDR_WIDTH'(3);
  // Saturating increment: stick at all-ones.
  assign fetch_count_d  = (&fetch_count_q) ? fetch_count_q
                                           : fetch_count_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      ifid_instr_q  <= '0;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        ST_RUN, ST_HALT_PEND: begin
          if (redirect_valid) begin
            // Redirect beats stall: the stall only protects IF/ID data that
            // the flush throws away anyway. A pending HALT is squashed too.
            pc_q         <= redirect_tgt_d;
            ifid_valid_q <= 1'b0;
            state_q      <= ST_RUN;
          end else if (stall) begin
            // hold everything
          end else if (state_q == ST_RUN) begin
            ifid_instr_q  <= imem_rdata;
            ifid_pc_q     <= pc_q;
            ifid_valid_q  <= 1'b1;
            fetch_count_q <= fetch_count_d;
            if (is_halt) begin
              // PC stays on the HALT so nothing past it is ever fetched.
              state_q <= ST_HALT_PEND;
            end else begin
              pc_q <= pc_seq_d;
            end
          end else begin
            // HALT has moved on to ID without being squashed.
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b1;
            state_q      <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          // frozen until reset
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int vectors;
  int miscompares;

  logic [31:0] mem [0:63];

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_SUB  = 32'h0022_1822;
  localparam logic [31:0] I_OR   = 32'h0022_1825;
  localparam logic [31:0] I_HALT = 32'h4400_0000;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Combinational instruction memory, 64 words, address wraps on bits [7:2].
  assign imem_rdata = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic e_valid, input logic e_halted,
                           input logic [31:0] e_count, input logic [31:0] e_addr);
    check({tag, ".ifid_pc"},     ifid_pc,     e_pc);
    check({tag, ".ifid_instr"},  ifid_instr,  e_instr);
    check({tag, ".ifid_valid"},  {31'd0, ifid_valid}, {31'd0, e_valid});
    check({tag, ".halted"},      {31'd0, halted},     {31'd0, e_halted});
    check({tag, ".fetch_count"}, fetch_count, e_count);
    check({tag, ".imem_addr"},   imem_addr,   e_addr);
    $display("step %-12s addr=%08h ifid_pc=%08h instr=%08h valid=%0b halted=%0b count=%0d",
             tag, imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_count);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
    mem[0] = I_ADD;
    mem[1] = I_SUB;
    mem[2] = I_OR;
    mem[3] = I_HALT;

    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0);
    reset = 1'b0;

    // Three free-running fetches, with a 2-cycle stall after the second.
    step();
    check_all("f0", 32'h0, I_ADD, 1'b1, 1'b0, 32'd1, 32'h4);
    step();
    check_all("f4", 32'h4, I_SUB, 1'b1, 1'b0, 32'd2, 32'h8);
    stall = 1'b1;
    step();
    check_all("stall1", 32'h4, I_SUB, 1'b1, 1'b0, 32'd2, 32'h8);
    step();
    check_all("stall2", 32'h4, I_SUB, 1'b1, 1'b0, 32'd2, 32'h8);
    stall = 1'b0;
    step();
    check_all("f8", 32'h8, I_OR, 1'b1, 1'b0, 32'd3, 32'hC);

    // Redirect together with stall: redirect wins, target aligned to 0x40.
    redirect_valid = 1'b1;
    stall          = 1'b1;
    redirect_pc    = 32'h41;
    step();
    check_all("redir40", 32'h8, I_OR, 1'b0, 1'b0, 32'd3, 32'h40);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    step();
    check_all("f40", 32'h40, 32'h2000_0010, 1'b1, 1'b0, 32'd4, 32'h44);

    // HALT fetched, then squashed by a redirect the next cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hC;
    step();
    check_all("redirC", 32'h40, 32'h2000_0010, 1'b0, 1'b0, 32'd4, 32'hC);
    redirect_valid = 1'b0;
    step();
    check_all("haltA", 32'hC, I_HALT, 1'b1, 1'b0, 32'd5, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    check_all("squash", 32'hC, I_HALT, 1'b0, 1'b0, 32'd5, 32'h20);
    redirect_valid = 1'b0;
    step();
    check_all("f20", 32'h20, 32'h2000_0008, 1'b1, 1'b0, 32'd6, 32'h24);

    // HALT not squashed: stall in HALT_PEND, then drain to HALTED.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hC;
    step();
    check_all("redirC2", 32'h20, 32'h2000_0008, 1'b0, 1'b0, 32'd6, 32'hC);
    redirect_valid = 1'b0;
    step();
    check_all("haltB", 32'hC, I_HALT, 1'b1, 1'b0, 32'd7, 32'hC);
    stall = 1'b1;
    step();
    check_all("pendstall", 32'hC, I_HALT, 1'b1, 1'b0, 32'd7, 32'hC);
    stall = 1'b0;
    step();
    check_all("halted", 32'hC, I_HALT, 1'b0, 1'b1, 32'd7, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    check_all("ignredir", 32'hC, I_HALT, 1'b0, 1'b1, 32'd7, 32'hC);
    redirect_valid = 1'b0;
    step();
    check_all("frozen", 32'hC, I_HALT, 1'b0, 1'b1, 32'd7, 32'hC);

    // Asynchronous reset away from the clock edge takes effect at once.
    #2;
    reset = 1'b1;
    #1;
    check_all("asyncrst", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 32'h0);
    step();
    reset = 1'b0;

    // PC wrap from the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    check_all("redirTop", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    check_all("fTop", 32'hFFFF_FFFC, 32'h2000_003F, 1'b1, 1'b0, 32'd1, 32'h0);
    step();
    check_all("fWrap", 32'h0, I_ADD, 1'b1, 1'b0, 32'd2, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
